enemy_missile_ctrl: RTL and testbench

//  Sequencer and arbiter for the single shared enemy-missile resource. Takes fire

---
 rtl/enemy_missile_pkg.sv | 33 +++
 rtl/enemy_missile_ctrl_rr_arbiter.sv | 33 +++
 rtl/enemy_missile_ctrl.sv | 179 +++++++++++++++++
 tb/tb_enemy_missile_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/enemy_missile_pkg.sv
// +----------------------------------------------------------------------------+
// | enemy_missile_pkg : shared types and constants for the enemy-missile block |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package enemy_missile_pkg;

  localparam int POS_W                   = 12;
  localparam int DEF_N_EN                = 4;
  localparam int DEF_SPEED               = 4;
  localparam int DEF_Y_LIMIT             = 768;
  localparam int DEF_Y_LAUNCH_OFFSET     = 40;
  localparam int DEF_COOLDOWN_FRAMES     = 30;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Galois feedback mask for x^8 + x^6 + x^5 + x^4 + 1 (right-shifting form)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    FLY      = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_missile_ctrl_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, searching upward from ptr     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[(int'(ptr) + k) % N]) begin
        valid = 1'b1;
        idx   = PTR_W'((int'(ptr) + k) % N);
        gnt[(int'(ptr) + k) % N] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/enemy_missile_ctrl.sv
// +----------------------------------------------------------------------------+
// | enemy_missile_ctrl : arbitrates, launches and flies the shared missile.    |
// | Optional ENEMY_MISSILE_JITTER_EN adds LFSR jitter to the cooldown length.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module enemy_missile_ctrl
  import enemy_missile_pkg::*;
#(
  parameter int N_EN            = DEF_N_EN,
  parameter int SPEED           = DEF_SPEED,
  parameter int Y_LIMIT         = DEF_Y_LIMIT,
  parameter int Y_LAUNCH_OFFSET = DEF_Y_LAUNCH_OFFSET,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  vsync_in,
  input  logic [N_EN-1:0]       fire_req,
  input  logic [POS_W*N_EN-1:0] en_xpos,
  input  logic [POS_W*N_EN-1:0] en_ypos,
  input  logic                  hit,
  output logic [POS_W-1:0]      xpos,
  output logic [POS_W-1:0]      ypos,
  output logic                  on,
  output logic [N_EN-1:0]       grant,
  output logic                  busy
);

  localparam int PTR_W = $clog2(N_EN);
`ifdef ENEMY_MISSILE_JITTER_EN
  localparam int CD_MAX = COOLDOWN_FRAMES + 15;
`else
  localparam int CD_MAX = COOLDOWN_FRAMES;
`endif
  localparam int CNT_W = (CD_MAX < 2) ? 1 : $clog2(CD_MAX + 1);

  localparam logic [POS_W:0]   SPEED_C  = (POS_W+1)'(SPEED);
  localparam logic [POS_W:0]   LIMIT_C  = (POS_W+1)'(Y_LIMIT);
  localparam logic [POS_W-1:0] OFFSET_C = POS_W'(Y_LAUNCH_OFFSET);

  state_e             state_q, state_d;
  logic               vsync_q;
  logic [POS_W-1:0]   xpos_q, xpos_d;
  logic [POS_W-1:0]   ypos_q, ypos_d;
  logic               on_q, on_d;
  logic [N_EN-1:0]    grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               tick;
  logic [N_EN-1:0]    arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [POS_W-1:0]   sel_x, sel_y;
  logic [POS_W:0]     ysum;
  logic [CNT_W-1:0]   cd_len;

  assign tick = vsync_in & ~vsync_q;

  rr_arbiter #(
    .N     (N_EN),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (fire_req),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign sel_x = en_xpos[int'(arb_idx)*POS_W +: POS_W];
  assign sel_y = en_ypos[int'(arb_idx)*POS_W +: POS_W];
  // 13-bit sum so a missile near the bottom of the 12-bit range cannot wrap past the limit
  assign ysum  = {1'b0, ypos_q} + SPEED_C;

`ifdef ENEMY_MISSILE_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d = tick ? lfsr_next(lfsr_q) : lfsr_q;
  assign cd_len = CNT_W'(COOLDOWN_FRAMES) + CNT_W'(lfsr_q[3:0]);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign cd_len = CNT_W'(COOLDOWN_FRAMES);
`endif

  always_comb begin
    state_d  = state_q;
    xpos_d   = xpos_q;
    ypos_d   = ypos_q;
    on_d     = on_q;
    grant_d  = '0;
    busy_d   = busy_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d  = arb_gnt;
          xpos_d   = sel_x;
          ypos_d   = sel_y + OFFSET_C;
          rr_ptr_d = (arb_idx == PTR_W'(N_EN - 1)) ? '0 : arb_idx + PTR_W'(1);
          busy_d   = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        on_d    = 1'b1;
        busy_d  = 1'b1;
        state_d = FLY;
      end
      FLY: begin
        if (hit || (tick && (ysum > LIMIT_C))) begin
          on_d    = 1'b0;
          cnt_d   = cd_len;
          state_d = COOLDOWN;
        end else if (tick) begin
          ypos_d = ysum[POS_W-1:0];
        end
      end
      COOLDOWN: begin
        // the tick that takes the count to zero (or finds it already zero) ends cooldown
        if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        on_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b0;
      xpos_q   <= '0;
      ypos_q   <= '0;
      on_q     <= 1'b0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= vsync_in;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      on_q     <= on_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign xpos  = xpos_q;
  assign ypos  = ypos_q;
  assign on    = on_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_missile_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_enemy_missile_ctrl : directed self-checking bench for enemy_missile_ctrl|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_enemy_missile_ctrl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vsync_in;
  logic [3:0]  fire_req;
  logic [47:0] en_xpos;
  logic [47:0] en_ypos;
  logic        hit;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        on;
  logic [3:0]  grant;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  enemy_missile_ctrl dut (
    .pclk     (pclk),
    .rst      (rst),
    .vsync_in (vsync_in),
    .fire_req (fire_req),
    .en_xpos  (en_xpos),
    .en_ypos  (en_ypos),
    .hit      (hit),
    .xpos     (xpos),
    .ypos     (ypos),
    .on       (on),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // one frame tick on the first edge, then vsync low so the edge detector rearms
  task automatic frame();
    vsync_in = 1'b1;
    cyc(1);
    vsync_in = 1'b0;
    cyc(1);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (grant == 4'b0 && n < 50) begin
      cyc(1);
      n++;
    end
  endtask

  initial begin
    rst = 1'b0; vsync_in = 1'b0; fire_req = '0; hit = 1'b0;
    en_xpos = '0; en_ypos = '0;
    en_xpos[0 +: 12] = 12'd10;  en_ypos[0 +: 12]  = 12'd60;
    en_xpos[12 +: 12] = 12'd20; en_ypos[12 +: 12] = 12'd70;
    en_xpos[24 +: 12] = 12'd100; en_ypos[24 +: 12] = 12'd50;
    en_xpos[36 +: 12] = 12'd40; en_ypos[36 +: 12] = 12'd80;
    cyc(2);
    check("rst_on", on, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_xpos", xpos, 0);
    check("rst_ypos", ypos, 0);
    rst = 1'b1;

    // single request from enemy 2
    fire_req = 4'b0100;
    cyc(1);
    check("t1_grant", grant, 4'b0100);
    check("t1_xpos", xpos, 100);
    check("t1_ypos", ypos, 90);
    check("t1_on_early", on, 0);
    check("t1_busy", busy, 1);
    fire_req = 4'b0000;
    cyc(1);
    check("t1_grant_clr", grant, 0);
    check("t1_on", on, 1);

    // flight, hit, cooldown; requests during flight/cooldown ignored
    fire_req = 4'b1000;
    repeat (10) frame();
    check("t3_ypos", ypos, 130);
    check("t3_xpos_held", xpos, 100);
    check("t3_on", on, 1);
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    check("t3_hit_on", on, 0);
    check("t3_hit_busy", busy, 1);
    fire_req = 4'b0001;
    repeat (29) frame();
    check("t3_cd29_busy", busy, 1);
    check("t3_cd29_xpos", xpos, 100);
    frame();
    check("t3_regrant", grant, 4'b0001);
    check("t3_regrant_x", xpos, 10);
    check("t3_regrant_y", ypos, 100);

    // tick landing in LAUNCH is ignored
    vsync_in = 1'b1;
    fire_req = 4'b0000;
    cyc(1);
    vsync_in = 1'b0;
    cyc(1);
    check("launch_tick_y", ypos, 100);
    check("launch_tick_on", on, 1);
    hit = 1'b1; cyc(1); hit = 1'b0;
    repeat (30) frame();
    check("cd_done_busy", busy, 0);

    // hit while idle does nothing
    hit = 1'b1; cyc(1); hit = 1'b0;
    check("idle_hit_busy", busy, 0);
    check("idle_hit_on", on, 0);

    // launch at 766, next tick retires without moving
    en_ypos[36 +: 12] = 12'd726;
    fire_req = 4'b1000;
    cyc(1);
    check("t4_grant", grant, 4'b1000);
    check("t4_ypos", ypos, 766);
    fire_req = 4'b0000;
    cyc(1);
    frame();
    check("t4_ret_y", ypos, 766);
    check("t4_ret_on", on, 0);
    check("t4_ret_busy", busy, 1);
    repeat (30) frame();

    // launch at 4094: a 12-bit compare would wrap and keep flying
    en_ypos[36 +: 12] = 12'd4054;
    fire_req = 4'b1000;
    cyc(1);
    check("wrap_ypos", ypos, 4094);
    fire_req = 4'b0000;
    cyc(1);
    frame();
    check("wrap_on", on, 0);
    check("wrap_y", ypos, 4094);
    repeat (30) frame();

    // exactly reaching the limit is allowed, exceeding it retires
    en_ypos[12 +: 12] = 12'd724;
    fire_req = 4'b0010;
    cyc(1);
    check("lim_grant", grant, 4'b0010);
    fire_req = 4'b0000;
    cyc(1);
    frame();
    check("lim_y768", ypos, 768);
    check("lim_on768", on, 1);
    frame();
    check("lim_ret_on", on, 0);
    check("lim_ret_y", ypos, 768);

    // strict rotation from reset with all requests set
    rst = 1'b0; cyc(1); rst = 1'b1;
    fire_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant();
      check($sformatf("rr_grant%0d", k), grant, 32'd1 << (k % 4));
      cyc(1);
      hit = 1'b1; cyc(1); hit = 1'b0;
      repeat (30) frame();
    end

    // asynchronous reset mid-flight
    wait_grant();
    fire_req = 4'b0000;
    cyc(1);
    check("t6_pre_on", on, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_on", on, 0);
    check("t6_busy", busy, 0);
    check("t6_ypos", ypos, 0);
    #1 rst = 1'b1;
    cyc(2);
    check("t6_after_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
